// File: rtl/tetris_move_checker.sv
// tetris_move_checker: validates one move request of the active piece against board bounds and occupancy
//   clk, reset                 : clock, synchronous active-high reset
//   spawn, spawn_shape         : load a new piece at (SPAWN_X, 0), rot 0; aborts a check in progress
//   req_valid/req_move/req_ready : move request handshake (00 left, 01 right, 10 down, 11 rotate)
//   done/accepted/landed       : result pulse and held result flags
//   rd_en/rd_x/rd_y/rd_data    : board occupancy read port, data one cycle after rd_en
//   piece_shape/rot/x/y        : current piece state
module tetris_piece_offsets (
  input  logic       i_shape,
  input  logic [1:0] i_rot,
  output logic [7:0] o_dx,
  output logic [7:0] o_dy
);
  // cell k occupies bits [2k+1:2k]; O is a fixed 2x2, I is a bar inside a 4x4 box
  always_comb begin
    o_dx = !i_shape ? 8'h44 : i_rot[0] ? (i_rot[1] ? 8'h55 : 8'hAA) : 8'hE4;
    o_dy = !i_shape ? 8'h50 : i_rot[0] ? 8'hE4 : (i_rot[1] ? 8'hAA : 8'h55);
  end
endmodule

module tetris_move_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int SPAWN_X = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn,
  input  logic       spawn_shape,
  input  logic       req_valid,
  input  logic [1:0] req_move,
  output logic       req_ready,
  output logic       done,
  output logic       accepted,
  output logic       landed,
  output logic       rd_en,
  output logic [3:0] rd_x,
  output logic [4:0] rd_y,
  input  logic       rd_data,
  output logic       piece_shape,
  output logic [1:0] piece_rot,
  output logic [3:0] piece_x,
  output logic [4:0] piece_y
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LAST, S_DECIDE} state_t;
  state_t      r_state;
  logic [1:0]  r_i, r_move, r_crot, r_rot;
  logic [5:0]  r_cx, r_cy;
  logic        r_fail, r_pend, r_done, r_acc, r_land, r_shape;
  logic [3:0]  r_x;
  logic [4:0]  r_y;
  logic [7:0]  w_dx, w_dy;
  logic [5:0]  w_ax, w_ay;
  logic        w_oob, w_rd_en, w_fail_next;
  tetris_piece_offsets u_off (.i_shape(r_shape), .i_rot(r_crot), .o_dx(w_dx), .o_dy(w_dy));
  assign w_ax = r_cx + {4'b0, w_dx[{r_i, 1'b0} +: 2]};
  assign w_ay = r_cy + {4'b0, w_dy[{r_i, 1'b0} +: 2]};
  // a negative column wraps to >= 32 in 6 bits, so the unsigned compare also catches ax < 0
  assign w_oob = (w_ax >= 6'(BOARD_W)) | (w_ay >= 6'(BOARD_H));
  assign w_rd_en = (r_state == S_CHECK) & ~w_oob;
  assign w_fail_next = r_fail | (r_pend & rd_data);
  assign rd_en = w_rd_en;
  assign rd_x = w_rd_en ? w_ax[3:0] : '0;
  assign rd_y = w_rd_en ? w_ay[4:0] : '0;
  assign req_ready = r_state == S_IDLE;
  assign done = r_done;
  assign accepted = r_acc;
  assign landed = r_land;
  assign piece_shape = r_shape;
  assign piece_rot = r_rot;
  assign piece_x = r_x;
  assign piece_y = r_y;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i <= '0;
      r_move <= '0;
      r_crot <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_fail <= 1'b0;
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_acc <= 1'b0;
      r_land <= 1'b0;
      r_shape <= 1'b0;
      r_rot <= '0;
      r_x <= 4'(SPAWN_X);
      r_y <= '0;
    end else if (spawn) begin
      r_state <= S_IDLE;
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_shape <= spawn_shape;
      r_rot <= '0;
      r_x <= 4'(SPAWN_X);
      r_y <= '0;
    end else begin
      r_pend <= w_rd_en;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_move <= req_move;
          r_cx <= req_move == 2'b00 ? {2'b0, r_x} - 6'd1 : req_move == 2'b01 ? {2'b0, r_x} + 6'd1 : {2'b0, r_x};
          r_cy <= {1'b0, r_y} + 6'(req_move == 2'b10);
          r_crot <= r_rot + 2'(req_move == 2'b11);
          r_fail <= 1'b0;
          r_i <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_fail <= w_fail_next | w_oob;
          r_i <= r_i + 2'd1;
          r_state <= r_i == 2'd3 ? S_LAST : S_CHECK;
        end
        S_LAST: begin
          r_done <= 1'b1;
          r_acc <= ~w_fail_next;
          r_land <= w_fail_next & (r_move == 2'b10);
          r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (r_acc) begin
            r_x <= r_cx[3:0];
            r_y <= r_cy[4:0];
            r_rot <= r_crot;
          end
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
